// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register with C/Z flag state; conditional execute gates rd and flag writes.
// Latency one cycle; stall holds every register, flush squashes the slot and wins over stall.
module ex_flag_stage #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_carry,
    input  logic          alu_zero,
    input  logic [1:0]    cond,
    input  logic          c_we,
    input  logic          z_we,
    input  logic [RW-1:0] rd,
    input  logic          rd_we,
    output logic          carry_flag,
    output logic          zero_flag,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_rd,
    output logic          out_rd_we,
    output logic          fwd_hit
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          rd_we_q, rd_we_d;
    logic          c_q, c_d;
    logic          z_q, z_d;
    logic          cond_true;
    logic          exec;

    always_comb begin
        cond_true = 1'b1;
        case (cond)
            2'b01:   cond_true = c_q;
            2'b10:   cond_true = z_q;
            default: cond_true = 1'b1;
        endcase
        exec = in_valid & cond_true;

        valid_d = valid_q;
        data_d  = data_q;
        rd_d    = rd_q;
        rd_we_d = rd_we_q;
        c_d     = c_q;
        z_d     = z_q;

        // flush leaves data/rd untouched; they are meaningless once valid drops
        if (flush) begin
            valid_d = 1'b0;
            rd_we_d = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
            data_d  = alu_out;
            rd_d    = rd;
            rd_we_d = rd_we & exec;
            if (c_we & exec) c_d = alu_carry;
            if (z_we & exec) z_d = alu_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            rd_q    <= '0;
            rd_we_q <= 1'b0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            rd_we_q <= rd_we_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    assign carry_flag = c_q;
    assign zero_flag  = z_q;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_rd     = rd_q;
    assign out_rd_we  = rd_we_q;
    assign fwd_hit    = valid_q & rd_we_q;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed vector table followed by randomized traffic against a reference model of ex_flag_stage.
module tb_ex_flag_stage;

    localparam int DW = 16;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst, in_valid, stall, flush, alu_carry, alu_zero, c_we, z_we, rd_we;
    logic [DW-1:0] alu_out;
    logic [1:0]    cond;
    logic [RW-1:0] rd;
    logic          carry_flag, zero_flag, out_valid, out_rd_we, fwd_hit;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_rd;

    int checks   = 0;
    int failures = 0;

    ex_flag_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero), .cond(cond),
        .c_we(c_we), .z_we(z_we), .rd(rd), .rd_we(rd_we),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .out_valid(out_valid),
        .out_data(out_data), .out_rd(out_rd), .out_rd_we(out_rd_we), .fwd_hit(fwd_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, iv, stall, flush;
        logic [DW-1:0] alu;
        logic          car, zer;
        logic [1:0]    cond;
        logic          cwe, zwe;
        logic [RW-1:0] rd;
        logic          rdwe;
        logic          e_v;
        logic [DW-1:0] e_d;
        logic [RW-1:0] e_rd;
        logic          e_we, e_c, e_z, e_dk;
    } vec_t;

    // Reference state: what the architecture says the registers hold
    logic          m_v, m_we, m_c, m_z, m_dk;
    logic [DW-1:0] m_d;
    logic [RW-1:0] m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic st, input logic fl,
                         input logic [DW-1:0] a, input logic ca, input logic ze,
                         input logic [1:0] cd, input logic cw, input logic zw,
                         input logic [RW-1:0] d, input logic dw);
        rst = r; in_valid = iv; stall = st; flush = fl; alu_out = a; alu_carry = ca;
        alu_zero = ze; cond = cd; c_we = cw; z_we = zw; rd = d; rd_we = dw;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [DW-1:0] d,
                             input logic [RW-1:0] r, input logic we, input logic c,
                             input logic z, input logic dk);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".out_rd_we"}, 32'(out_rd_we), 32'(we));
        chk({tag, ".carry_flag"}, 32'(carry_flag), 32'(c));
        chk({tag, ".zero_flag"}, 32'(zero_flag), 32'(z));
        chk({tag, ".fwd_hit"}, 32'(fwd_hit), 32'(v & we));
        if (dk) begin
            chk({tag, ".out_data"}, 32'(out_data), 32'(d));
            chk({tag, ".out_rd"}, 32'(out_rd), 32'(r));
        end
    endtask

    // Next-state of the reference from the current inputs, in priority order rst > flush > stall
    task automatic model_step();
        logic ok;
        ok = (cond == 2'b01) ? m_c : (cond == 2'b10) ? m_z : 1'b1;
        if (rst) begin
            m_v = 0; m_d = '0; m_rd = '0; m_we = 0; m_c = 0; m_z = 0; m_dk = 1;
        end else if (flush) begin
            m_v = 0; m_we = 0; m_dk = 0;
        end else if (!stall) begin
            m_v  = in_valid;
            m_d  = alu_out;
            m_rd = rd;
            m_we = rd_we && in_valid && ok;
            if (in_valid && ok && c_we) m_c = alu_carry;
            if (in_valid && ok && z_we) m_z = alu_zero;
            m_dk = 1;
        end
    endtask

    vec_t vecs[16];

    initial begin
        drive(1, 0, 0, 0, '0, 0, 0, 2'b00, 0, 0, '0, 0);

        //          rst iv st fl alu       car zer cond  cw zw rd rdwe | v  data      rd we C  Z  dk
        vecs[0]  = '{1, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 0, 1};
        vecs[1]  = '{0, 1, 0, 0, 16'h0000, 1, 1, 2'b00, 1, 1, 3, 1,  1, 16'h0000, 3, 1, 1, 1, 1};
        vecs[2]  = '{1, 1, 1, 1, 16'hFFFF, 0, 1, 2'b00, 1, 1, 5, 1,  0, 16'h0000, 0, 0, 0, 0, 1};
        vecs[3]  = '{0, 1, 0, 0, 16'h1234, 1, 0, 2'b01, 1, 0, 5, 1,  1, 16'h1234, 5, 0, 0, 0, 1};
        vecs[4]  = '{0, 1, 0, 0, 16'h00AA, 1, 0, 2'b00, 1, 0, 2, 1,  1, 16'h00AA, 2, 1, 1, 0, 1};
        vecs[5]  = '{0, 1, 0, 0, 16'h0055, 0, 0, 2'b01, 0, 0, 4, 1,  1, 16'h0055, 4, 1, 1, 0, 1};
        vecs[6]  = '{0, 1, 0, 0, 16'h0BAD, 0, 1, 2'b10, 1, 1, 6, 1,  1, 16'h0BAD, 6, 0, 1, 0, 1};
        vecs[7]  = '{0, 1, 0, 0, 16'h0C0C, 0, 1, 2'b11, 1, 1, 1, 1,  1, 16'h0C0C, 1, 1, 0, 1, 1};
        vecs[8]  = '{0, 1, 1, 0, 16'h1111, 1, 0, 2'b00, 1, 1, 2, 0,  1, 16'h0C0C, 1, 1, 0, 1, 1};
        vecs[9]  = '{0, 0, 1, 0, 16'h2222, 1, 0, 2'b11, 1, 1, 3, 1,  1, 16'h0C0C, 1, 1, 0, 1, 1};
        vecs[10] = '{0, 1, 1, 0, 16'h3333, 1, 0, 2'b10, 1, 1, 4, 1,  1, 16'h0C0C, 1, 1, 0, 1, 1};
        vecs[11] = '{0, 1, 1, 1, 16'h4444, 1, 0, 2'b00, 1, 1, 5, 1,  0, 16'h0000, 0, 0, 0, 1, 0};
        vecs[12] = '{0, 0, 0, 0, 16'h1111, 1, 0, 2'b00, 1, 1, 7, 1,  0, 16'h1111, 7, 0, 0, 1, 1};
        vecs[13] = '{0, 1, 0, 0, 16'h2222, 0, 0, 2'b10, 0, 1, 2, 1,  1, 16'h2222, 2, 1, 0, 0, 1};
        vecs[14] = '{1, 1, 0, 0, 16'h5555, 1, 1, 2'b00, 1, 1, 6, 1,  0, 16'h0000, 0, 0, 0, 0, 1};
        vecs[15] = '{0, 1, 0, 0, 16'hABCD, 1, 0, 2'b00, 1, 0, 7, 1,  1, 16'hABCD, 7, 1, 1, 0, 1};

        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].stall, vecs[i].flush, vecs[i].alu,
                  vecs[i].car, vecs[i].zer, vecs[i].cond, vecs[i].cwe, vecs[i].zwe,
                  vecs[i].rd, vecs[i].rdwe);
            #1;
            // flags are pure flop outputs, so new inputs must not move them before the edge
            if (i > 0) begin
                chk($sformatf("vec%0d.c_pre_edge", i), 32'(carry_flag), 32'(vecs[i-1].e_c));
                chk($sformatf("vec%0d.z_pre_edge", i), 32'(zero_flag), 32'(vecs[i-1].e_z));
            end
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_d, vecs[i].e_rd,
                      vecs[i].e_we, vecs[i].e_c, vecs[i].e_z, vecs[i].e_dk);
        end

        m_v = vecs[15].e_v; m_d = vecs[15].e_d; m_rd = vecs[15].e_rd; m_we = vecs[15].e_we;
        m_c = vecs[15].e_c; m_z = vecs[15].e_z; m_dk = 1;

        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(63) == 0), ($urandom_range(3) != 0), ($urandom_range(3) == 0),
                  ($urandom_range(7) == 0), DW'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom), 1'($urandom), 1'($urandom), RW'($urandom), 1'($urandom));
            model_step();
            @(posedge clk); #1;
            check_all($sformatf("rand%0d", n), m_v, m_d, m_rd, m_we, m_c, m_z, m_dk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
